// File: rtl/input_reduce_acc.sv
// input_reduce_acc: folds a frame of WIDTH-bit beats into OR / AND / XOR
// reductions, counts the beats (saturating) and holds the frame result
// until the consumer takes it. The reduction reported on sel_out comes from
// the mode sampled on the frame's first beat.
module input_reduce_acc #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             or_out,
  output logic             nor_out,
  output logic             sel_out,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic             or_acc_reg, or_acc_next;
  logic             and_acc_reg, and_acc_next;
  logic             xor_acc_reg, xor_acc_next;
  logic [1:0]       mode_reg, mode_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             nor_out_reg;
  logic             sel_out_reg;
  logic             sel_next;
  logic             accept;

  // Per-beat reductions built as explicit bit chains across the input word.
  logic [WIDTH-1:0] or_chain, and_chain, xor_chain;
  logic             beat_or, beat_and, beat_xor;

  assign or_chain[0]  = in_data[0];
  assign and_chain[0] = in_data[0];
  assign xor_chain[0] = in_data[0];

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_reduce
      assign or_chain[gi]  = or_chain[gi-1]  | in_data[gi];
      assign and_chain[gi] = and_chain[gi-1] & in_data[gi];
      assign xor_chain[gi] = xor_chain[gi-1] ^ in_data[gi];
    end
  endgenerate

  assign beat_or  = or_chain[WIDTH-1];
  assign beat_and = and_chain[WIDTH-1];
  assign beat_xor = xor_chain[WIDTH-1];

  // Ready is a registered flag, so acceptance depends only on state.
  assign accept = in_valid & in_ready_reg;

  // Next-state and accumulator update; everything holds unless changed below.
  always_comb begin
    state_next   = state_reg;
    or_acc_next  = or_acc_reg;
    and_acc_next = and_acc_reg;
    xor_acc_next = xor_acc_reg;
    mode_next    = mode_reg;
    cnt_next     = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          or_acc_next  = beat_or;
          and_acc_next = beat_and;
          xor_acc_next = beat_xor;
          mode_next    = mode;
          cnt_next     = CNT_ONE;
          state_next   = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          or_acc_next  = or_acc_reg  | beat_or;
          and_acc_next = and_acc_reg & beat_and;
          xor_acc_next = xor_acc_reg ^ beat_xor;
          if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
          end
          state_next = in_last ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reduction selected by the mode latched at the start of the frame.
  always_comb begin
    sel_next = 1'b0;
    case (mode_next)
      2'd0:    sel_next = or_acc_next;
      2'd1:    sel_next = and_acc_next;
      2'd2:    sel_next = xor_acc_next;
      default: sel_next = ~or_acc_next;
    endcase
  end

  // State, accumulators and registered output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      or_acc_reg    <= 1'b0;
      and_acc_reg   <= 1'b0;
      xor_acc_reg   <= 1'b0;
      mode_reg      <= 2'd0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      nor_out_reg   <= 1'b1;
      sel_out_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      or_acc_reg    <= or_acc_next;
      and_acc_reg   <= and_acc_next;
      xor_acc_reg   <= xor_acc_next;
      mode_reg      <= mode_next;
      cnt_reg       <= cnt_next;
      in_ready_reg  <= (state_next != HOLD);
      out_valid_reg <= (state_next == HOLD);
      nor_out_reg   <= ~or_acc_next;
      sel_out_reg   <= sel_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign or_out    = or_acc_reg;
  assign nor_out   = nor_out_reg;
  assign sel_out   = sel_out_reg;
  assign beat_cnt  = cnt_reg;

endmodule

// File: tb/tb_input_reduce_acc.sv
// Testbench for input_reduce_acc: directed frames plus randomized frames,
// checked against a frame-level reference computed from bit counts.
// Two instances share the stimulus: default CNT_W=4 and CNT_W=2.
module tb_input_reduce_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic [1:0] mode;
  logic       out_ready;

  logic       in_ready4, out_valid4, or_out4, nor_out4, sel_out4;
  logic [3:0] beat_cnt4;
  logic       in_ready2, out_valid2, or_out2, nor_out2, sel_out2;
  logic [1:0] beat_cnt2;

  int checks = 0;
  int errors = 0;

  // Frame description consumed by run_frame.
  logic [3:0] fd[$];
  logic [1:0] fm[$];

  always #5 clk = ~clk;

  input_reduce_acc #(.WIDTH(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_last(in_last), .mode(mode),
    .out_valid(out_valid4), .out_ready(out_ready), .or_out(or_out4),
    .nor_out(nor_out4), .sel_out(sel_out4), .beat_cnt(beat_cnt4)
  );

  input_reduce_acc #(.WIDTH(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .mode(mode),
    .out_valid(out_valid2), .out_ready(out_ready), .or_out(or_out2),
    .nor_out(nor_out2), .sel_out(sel_out2), .beat_cnt(beat_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic junk_inputs();
    in_data = 4'($urandom);
    in_last = 1'($urandom);
    mode    = 2'($urandom);
  endtask

  task automatic drive_beat(input logic [3:0] d, input logic l, input logic [1:0] m);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l; mode = m;
    chk("in_ready_beat", {31'd0, in_ready4}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    junk_inputs();
    if (!l) chk("out_valid_mid", {31'd0, out_valid4}, 32'd0);
  endtask

  // Frame-level model: result depends only on the total one-count, whether
  // every bit was one, the beat count, and the first beat's mode.
  task automatic check_result(input string tag, input logic eor, input logic esel,
                              input int ecnt);
    int e4, e2;
    e4 = (ecnt > 15) ? 15 : ecnt;
    e2 = (ecnt > 3) ? 3 : ecnt;
    chk({tag, "_valid"},  {31'd0, out_valid4}, 32'd1);
    chk({tag, "_ready"},  {31'd0, in_ready4}, 32'd0);
    chk({tag, "_or"},     {31'd0, or_out4}, {31'd0, eor});
    chk({tag, "_nor"},    {31'd0, nor_out4}, {31'd0, ~eor});
    chk({tag, "_sel"},    {31'd0, sel_out4}, {31'd0, esel});
    chk({tag, "_cnt4"},   {28'd0, beat_cnt4}, 32'(e4));
    chk({tag, "_cnt2"},   {30'd0, beat_cnt2}, 32'(e2));
    chk({tag, "_sel2"},   {31'd0, sel_out2}, {31'd0, esel});
  endtask

  task automatic run_frame(input string tag, input int max_gap, input int hold_cycles);
    int  ones, n;
    bit  all_ones;
    logic [1:0] fmode;
    logic eor, esel;
    n = fd.size();
    ones = 0; all_ones = 1'b1; fmode = fm[0];
    for (int i = 0; i < n; i++) begin
      ones += $countones(fd[i]);
      if (fd[i] != 4'hF) all_ones = 1'b0;
      drive_beat(fd[i], (i == n - 1), fm[i]);
      if (i != n - 1) begin
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) begin
          @(negedge clk); in_valid = 1'b0; junk_inputs();
        end
      end
    end
    eor = (ones > 0);
    case (fmode)
      2'd0: esel = eor;
      2'd1: esel = all_ones;
      2'd2: esel = ones[0];
      default: esel = ~eor;
    endcase
    check_result(tag, eor, esel, n);
    // Offer beats while the result is held; none may be absorbed.
    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk); in_valid = 1'b1; junk_inputs(); out_ready = 1'b0;
      @(posedge clk); #1;
      check_result({tag, "_hold"}, eor, esel, n);
    end
    @(negedge clk); in_valid = 1'b1; junk_inputs(); out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk({tag, "_release_valid"}, {31'd0, out_valid4}, 32'd0);
    chk({tag, "_release_ready"}, {31'd0, in_ready4}, 32'd1);
    fd.delete(); fm.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    mode = 2'd0; out_ready = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid4}, 32'd0);
    chk("rst_ready", {31'd0, in_ready4}, 32'd1);
    chk("rst_or",    {31'd0, or_out4}, 32'd0);
    chk("rst_nor",   {31'd0, nor_out4}, 32'd1);
    chk("rst_sel",   {31'd0, sel_out4}, 32'd0);
    chk("rst_cnt",   {28'd0, beat_cnt4}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // All 16 single-beat frames, OR mode.
    for (int v = 0; v < 16; v++) begin
      fd.push_back(4'(v)); fm.push_back(2'd0);
      run_frame($sformatf("single%0d", v), 0, 0);
    end

    // Parity over three beats.
    fd = '{4'b0001, 4'b0011, 4'b0100}; fm = '{2'd2, 2'd2, 2'd2};
    run_frame("xor3", 0, 0);

    // AND mode with a mid-frame mode change that must be ignored.
    fd = '{4'b1111, 4'b1110}; fm = '{2'd1, 2'd0};
    run_frame("and_modechg", 1, 0);

    // Result held for 5 cycles under backpressure.
    fd = '{4'b1111, 4'b1111}; fm = '{2'd1, 2'd3};
    run_frame("hold5", 0, 5);

    // Six beats: CNT_W=2 instance saturates at 3.
    fd = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    fm = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
    run_frame("sat6", 1, 1);

    // Seventeen beats: CNT_W=4 instance saturates at 15.
    for (int i = 0; i < 17; i++) begin fd.push_back(4'hF); fm.push_back(2'd1); end
    run_frame("sat17", 0, 0);

    // Asynchronous reset in the middle of a frame.
    drive_beat(4'b1010, 1'b0, 2'd2);
    drive_beat(4'b0110, 1'b0, 2'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid4}, 32'd0);
    chk("arst_ready", {31'd0, in_ready4}, 32'd1);
    chk("arst_or",    {31'd0, or_out4}, 32'd0);
    chk("arst_nor",   {31'd0, nor_out4}, 32'd1);
    chk("arst_sel",   {31'd0, sel_out4}, 32'd0);
    chk("arst_cnt",   {28'd0, beat_cnt4}, 32'd0);
    @(negedge clk); in_valid = 1'b1; in_data = 4'hF; in_last = 1'b1; mode = 2'd1;
    @(posedge clk); #1;
    chk("arst_noaccept_valid", {31'd0, out_valid4}, 32'd0);
    chk("arst_noaccept_or",    {31'd0, or_out4}, 32'd0);
    chk("arst_noaccept_ready", {31'd0, in_ready4}, 32'd1);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    fd = '{4'b0000}; fm = '{2'd0};
    run_frame("after_rst", 0, 0);

    // Randomized frames with gaps, mid-frame mode noise and backpressure.
    for (int f = 0; f < 30; f++) begin
      int len;
      len = int'($urandom_range(8, 1));
      for (int i = 0; i < len; i++) begin
        fd.push_back(4'($urandom));
        fm.push_back(2'($urandom));
      end
      run_frame($sformatf("rand%0d", f), 2, int'($urandom_range(3, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
